// File: rtl/scan_pkg.sv
// Shared types and sizes for the scan index sequencer.
package scan_pkg;

   localparam int IDX_WIDTH = 3;
   localparam int NUM_POS   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } scan_state_t;

endpackage

// File: rtl/next_pos_finder.sv
// Rotating-priority search: first set mask bit after cur, wrapping, ending at cur itself.
module next_pos_finder
   import scan_pkg::*;
(
   input  logic [IDX_WIDTH-1:0] cur,
   input  logic [NUM_POS-1:0]   mask,
   input  logic                 dir,
   output logic [IDX_WIDTH-1:0] next_idx,
   output logic                 found
);

   logic [IDX_WIDTH-1:0] cand;

   // Walk from the farthest offset down so the nearest hit is the one left standing;
   // offset NUM_POS truncates to cur itself, giving the end-at-self case.
   always_comb begin
      next_idx = cur;
      found    = 1'b0;
      cand     = cur;
      for (int i = NUM_POS; i >= 1; i--) begin
         cand = dir ? (cur - IDX_WIDTH'(i)) : (cur + IDX_WIDTH'(i));
         if (mask[cand]) begin
            next_idx = cand;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/scan_index_sequencer.sv
// Scan index sequencer: steps a 3-bit index through enabled mask positions, prescaled or single-step.
// Build option SCAN_REVERSE_EN adds a dir input selecting downward search.
module scan_index_sequencer
   import scan_pkg::*;
#(
   parameter int DIV_WIDTH = 16
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 mode,
   input  logic                 step,
   input  logic [NUM_POS-1:0]   mask,
   input  logic [DIV_WIDTH-1:0] div_value,
`ifdef SCAN_REVERSE_EN
   input  logic                 dir,
`endif
   output logic [IDX_WIDTH-1:0] data_out,
   output logic                 tick,
   output logic                 active
);

   scan_state_t          state;
   scan_state_t          next_state;
   logic [DIV_WIDTH-1:0] presc;
   logic [DIV_WIDTH-1:0] presc_nxt;
   logic                 adv;
   logic                 search_dir;
   logic [IDX_WIDTH-1:0] nxt_idx;
   logic                 found;

`ifdef SCAN_REVERSE_EN
   assign search_dir = dir;
`else
   assign search_dir = 1'b0;
`endif

   next_pos_finder u_finder (
      .cur      (data_out),
      .mask     (mask),
      .dir      (search_dir),
      .next_idx (nxt_idx),
      .found    (found)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (enable) next_state = mode ? STEP : RUN;
         RUN: begin
            if (!enable)   next_state = IDLE;
            else if (mode) next_state = STEP;
         end
         STEP: begin
            if (!enable)    next_state = IDLE;
            else if (!mode) next_state = RUN;
         end
         default: next_state = IDLE;
      endcase
   end

   // Advances happen only while staying in RUN or STEP; any transition cycle clears the prescaler.
   always_comb begin
      presc_nxt = '0;
      adv       = 1'b0;
      if (state == RUN && next_state == RUN) begin
         if (presc >= div_value) adv = 1'b1;
         else                    presc_nxt = presc + DIV_WIDTH'(1);
      end
      if (state == STEP && next_state == STEP && step) adv = 1'b1;
   end

   // Output stage: data_out and tick update together one cycle after the advance condition.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc    <= '0;
         data_out <= '0;
         tick     <= 1'b0;
      end else begin
         presc <= presc_nxt;
         tick  <= adv && found;
         if (adv && found) data_out <= nxt_idx;
      end
   end

   assign active = ((state == RUN) || (state == STEP)) && (|mask);

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Directed self-checking bench for scan_index_sequencer (reverse test runs when SCAN_REVERSE_EN is defined).
module tb_scan_index_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        mode;
   logic        step;
   logic [7:0]  mask;
   logic [15:0] div_value;
   logic        dir;
   logic [2:0]  data_out;
   logic        tick;
   logic        active;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   scan_index_sequencer #(.DIV_WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .mode      (mode),
      .step      (step),
      .mask      (mask),
      .div_value (div_value),
`ifdef SCAN_REVERSE_EN
      .dir       (dir),
`endif
      .data_out  (data_out),
      .tick      (tick),
      .active    (active)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      enable = 1'b1; mode = 1'b0; step = 1'b0; mask = 8'hFF; div_value = 16'd0; dir = 1'b0;
      rst = 1'b1;
      cyc(); cyc();
      checks++; if (data_out !== 3'd0) begin errors++; $display("FAIL reset_data_out: got %0d want 0", data_out); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
      rst = 1'b0;
      cyc();
      checks++; if (active !== 1'b1 || tick !== 1'b0) begin errors++; $display("FAIL enter_run: active=%b tick=%b want 1 0", active, tick); end
      for (int k = 1; k <= 8; k++) begin
         cyc();
         checks++;
         if (data_out !== 3'(k % 8) || tick !== 1'b1) begin
            errors++; $display("FAIL run_div0[%0d]: data_out=%0d tick=%b want %0d 1", k, data_out, tick, k % 8);
         end
      end
   endtask

   task automatic test_prescale();
      div_value = 16'd3;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         checks++;
         if (data_out !== 3'(c / 4) || tick !== ((c % 4) == 0)) begin
            errors++; $display("FAIL prescale[%0d]: data_out=%0d tick=%b want %0d %b", c, data_out, tick, c / 4, (c % 4) == 0);
         end
      end
   endtask

   task automatic test_mask_skip();
      logic [2:0] exp_seq [4];
      exp_seq = '{3'd2, 3'd7, 3'd0, 3'd2};
      rst = 1'b1; mask = 8'b1000_0101; div_value = 16'd0; mode = 1'b0; enable = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      checks++; if (data_out !== 3'd0 || tick !== 1'b0) begin errors++; $display("FAIL skip_start: data_out=%0d tick=%b want 0 0", data_out, tick); end
      for (int k = 0; k < 4; k++) begin
         cyc();
         checks++;
         if (data_out !== exp_seq[k] || tick !== 1'b1) begin
            errors++; $display("FAIL skip_seq[%0d]: data_out=%0d tick=%b want %0d 1", k, data_out, tick, exp_seq[k]);
         end
      end
      mask = 8'h00;
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if (data_out !== 3'd2 || tick !== 1'b0 || active !== 1'b0) begin
            errors++; $display("FAIL mask_zero[%0d]: data_out=%0d tick=%b active=%b want 2 0 0", k, data_out, tick, active);
         end
      end
   endtask

   task automatic test_single();
      mask = 8'b0001_0000;
      for (int k = 0; k < 4; k++) begin
         cyc();
         checks++;
         if (data_out !== 3'd4 || tick !== 1'b1) begin
            errors++; $display("FAIL single[%0d]: data_out=%0d tick=%b want 4 1", k, data_out, tick);
         end
      end
   endtask

   task automatic test_step();
      int ticks;
      rst = 1'b1; mask = 8'hFF; mode = 1'b1; step = 1'b0; enable = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      ticks = 0;
      for (int p = 1; p <= 3; p++) begin
         step = 1'b1;
         cyc();
         if (tick === 1'b1) ticks++;
         checks++; if (data_out !== 3'(p)) begin errors++; $display("FAIL step_pulse[%0d]: data_out=%0d want %0d", p, data_out, p); end
         step = 1'b0;
         cyc();
         if (tick === 1'b1) ticks++;
         cyc();
         if (tick === 1'b1) ticks++;
      end
      checks++; if (ticks != 3) begin errors++; $display("FAIL step_tick_count: got %0d want 3", ticks); end
      step = 1'b1;
      for (int k = 4; k <= 7; k++) begin
         cyc();
         checks++;
         if (data_out !== 3'(k) || tick !== 1'b1) begin
            errors++; $display("FAIL step_held[%0d]: data_out=%0d tick=%b want %0d 1", k, data_out, tick, k);
         end
      end
      enable = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cyc();
         checks++;
         if (data_out !== 3'd7 || tick !== 1'b0 || active !== 1'b0) begin
            errors++; $display("FAIL step_disable[%0d]: data_out=%0d tick=%b active=%b want 7 0 0", k, data_out, tick, active);
         end
      end
      step = 1'b0;
   endtask

   task automatic test_reset_mid();
      enable = 1'b1; mode = 1'b0; mask = 8'hFF; div_value = 16'd0;
      cyc();
      cyc();
      checks++; if (data_out !== 3'd0 || tick !== 1'b1) begin errors++; $display("FAIL resume_from_held: data_out=%0d tick=%b want 0 1", data_out, tick); end
      cyc(); cyc();
      checks++; if (data_out !== 3'd2) begin errors++; $display("FAIL pre_reset: data_out=%0d want 2", data_out); end
      rst = 1'b1;
      cyc();
      checks++;
      if (data_out !== 3'd0 || tick !== 1'b0 || active !== 1'b0) begin
         errors++; $display("FAIL mid_reset: data_out=%0d tick=%b active=%b want 0 0 0", data_out, tick, active);
      end
      rst = 1'b0;
   endtask

`ifdef SCAN_REVERSE_EN
   task automatic test_reverse();
      logic [2:0] exp_seq [3];
      exp_seq = '{3'd7, 3'd2, 3'd0};
      rst = 1'b1; dir = 1'b1; mask = 8'b1000_0101; mode = 1'b0; enable = 1'b1; div_value = 16'd0;
      cyc();
      rst = 1'b0;
      cyc();
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if (data_out !== exp_seq[k] || tick !== 1'b1) begin
            errors++; $display("FAIL reverse[%0d]: data_out=%0d tick=%b want %0d 1", k, data_out, tick, exp_seq[k]);
         end
      end
      dir = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_prescale();
      test_mask_skip();
      test_single();
      test_step();
      test_reset_mid();
`ifdef SCAN_REVERSE_EN
      test_reverse();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
